// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Data-memory responder for the Memory stage of the pipeline. The M stage
// presents a load or store (address = ALUOutM, store data = WriteDataM). The
// access is performed on the edge that accepts it. The response (load data and
// error flag) is presented LATENCY cycles later with a one-cycle rvalid pulse.
// The pipeline is held with stall for the whole time in between. Word and byte
// accesses are supported on a word-organised array.
//
// Handshake: while idle, req_valid high is a request and stall follows it
// combinationally. The request is accepted on the first rising edge that sees
// it. The requester holds its inputs until the rvalid cycle. In that cycle
// stall is low and the pipeline advances. A req_valid still high in the rvalid
// cycle belongs to the finished request. A new request is accepted from the
// following idle cycle onward.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (power of two)
//   LATENCY      stall cycles per access, including the accept cycle (1..15)
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset; aborts any access in flight
//   req_valid  in   M stage holds a load/store
//   req_write  in   1 = store, 0 = load
//   req_byte   in   1 = byte access, 0 = word access
//   addr       in   byte address
//   wdata      in   store data; byte stores use wdata[7:0]
//   rdata      out  load data, valid with rvalid, held until the next accept
//   rvalid     out  one-cycle completion pulse
//   stall      out  pipeline freeze
//   err        out  misaligned or out-of-range access, valid with rvalid
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        stall,
  output logic        err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Complete FSM state in one struct, so checkers can bind to a single signal.
  typedef struct packed {
    state_t     state;
    logic [3:0] cnt;
  } fsm_t;

  fsm_t fsm_q;
  fsm_t fsm_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] rdata_q;
  logic        err_q;

  logic [29:0]   word_idx;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          misaligned;
  logic          out_of_range;
  logic          acc_err;
  logic          accept;
  logic [7:0]    lane_byte;

  // Address decode for the request presented this cycle.
  assign word_idx     = addr[31:2];
  assign idx          = addr[AW+1:2];
  assign lane         = addr[1:0];
  assign misaligned   = !req_byte && (lane != 2'b00);
  assign out_of_range = word_idx >= 30'(DEPTH_WORDS);
  assign acc_err      = misaligned || out_of_range;
  assign lane_byte    = mem[idx][{lane, 3'b000} +: 8];

  // Next-state logic and handshake outputs.
  always_comb begin
    fsm_d  = fsm_q;
    stall  = 1'b0;
    rvalid = 1'b0;
    accept = 1'b0;
    case (fsm_q.state)
      IDLE: begin
        stall = req_valid;
        if (req_valid) begin
          accept      = 1'b1;
          fsm_d.state = WAIT;
          fsm_d.cnt   = 4'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (fsm_q.cnt != 4'd0) begin
          stall     = 1'b1;
          fsm_d.cnt = fsm_q.cnt - 4'd1;
        end else begin
          rvalid      = 1'b1;
          fsm_d.state = IDLE;
        end
      end
      default: begin
        fsm_d.state = IDLE;
        fsm_d.cnt   = 4'd0;
      end
    endcase
  end

  // State register and response registers. The response is captured at the
  // accept edge and held until the next accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q.state <= IDLE;
      fsm_q.cnt   <= 4'd0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      if (accept) begin
        err_q <= acc_err;
        if (acc_err || req_write) begin
          rdata_q <= 32'd0;
        end else if (req_byte) begin
          rdata_q <= {24'd0, lane_byte};
        end else begin
          rdata_q <= mem[idx];
        end
      end
    end
  end

  // Array write port. The contents survive reset. A store that arrives
  // together with reset is dropped with the rest of the access.
  always_ff @(posedge clk) begin
    if (!reset && accept && req_write && !acc_err) begin
      if (req_byte) begin
        mem[idx][{lane, 3'b000} +: 8] <= wdata[7:0];
      end else begin
        mem[idx] <= wdata;
      end
    end
  end

  assign rdata = rdata_q;
  assign err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed bench for dmem_responder.
//   u_dut : LATENCY = 2, DEPTH_WORDS = 256 (main instance)
//   u_l1  : LATENCY = 1, DEPTH_WORDS = 256 (back-to-back timing only)
// Each issued access pushes its expected rdata and err onto the scoreboard
// queues. The entries are popped and compared when the DUT raises rvalid.
// Outputs are sampled 1 time unit after the falling edge.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main DUT (LATENCY = 2) ----------------
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic        req_byte  = 1'b0;
  logic [31:0] addr      = 32'd0;
  logic [31:0] wdata     = 32'd0;
  logic [31:0] rdata;
  logic        rvalid;
  logic        stall;
  logic        err;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_byte  (req_byte),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .stall     (stall),
    .err       (err)
  );

  // ---------------- second DUT (LATENCY = 1) ----------------
  logic        b_req_valid = 1'b0;
  logic        b_req_write = 1'b0;
  logic        b_req_byte  = 1'b0;
  logic [31:0] b_addr      = 32'd0;
  logic [31:0] b_wdata     = 32'd0;
  logic [31:0] b_rdata;
  logic        b_rvalid;
  logic        b_stall;
  logic        b_err;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_l1 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (b_req_valid),
    .req_write (b_req_write),
    .req_byte  (b_req_byte),
    .addr      (b_addr),
    .wdata     (b_wdata),
    .rdata     (b_rdata),
    .rvalid    (b_rvalid),
    .stall     (b_stall),
    .err       (b_err)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag, input logic [31:0] rd, input logic er);
    logic [31:0] e;
    logic        ee;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_unexpected observed=rvalid expected=no_response", tag);
    end else begin
      e  = exp_q.pop_front();
      ee = exp_err_q.pop_front();
      chk({tag, "_rdata"}, rd, e);
      chk({tag, "_err"}, 32'(er), 32'(ee));
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic w, input logic b, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_byte  = b;
    addr      = a;
    wdata     = d;
  endtask

  // One complete access on u_dut: the request is held until rvalid and
  // dropped the cycle after.
  task automatic access(input string tag, input logic w, input logic b,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_err);
    int k;
    @(negedge clk);
    drive(w, b, a, d);
    exp_q.push_back(exp_rd);
    exp_err_q.push_back(exp_err);
    #1;
    chk({tag, "_stall_accept"}, 32'(stall), 32'd1);
    chk({tag, "_rvalid_accept"}, 32'(rvalid), 32'd0);
    for (k = 1; k <= 16; k++) begin
      @(negedge clk);
      #1;
      if (rvalid) break;
      chk({tag, "_stall_wait"}, 32'(stall), 32'd1);
    end
    chk({tag, "_latency"}, 32'(k), 32'd2);
    if (rvalid) begin
      chk({tag, "_stall_resp"}, 32'(stall), 32'd0);
      pop_check(tag, rdata, err);
    end else begin
      void'(exp_q.pop_front());
      void'(exp_err_q.pop_front());
    end
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk({tag, "_idle_stall"}, 32'(stall), 32'd0);
    chk({tag, "_idle_rvalid"}, 32'(rvalid), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  logic exp_st[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic exp_rv[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic exp_st1[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic exp_rv1[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    // 1: reset
    repeat (2) @(negedge clk);
    #1;
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_rvalid", 32'(rvalid), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_l1_stall", 32'(b_stall), 32'd0);
    chk("reset_l1_rvalid", 32'(b_rvalid), 32'd0);
    reset = 1'b0;

    // 2: word store then word load
    access("st_word", 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
    access("ld_word", 1'b0, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);

    // 3: byte store into lane 2, word readback, byte load of lane 3
    access("st_byte", 1'b1, 1'b1, 32'h12, 32'hFFFFFF5A, 32'd0, 1'b0);
    access("ld_after_sb", 1'b0, 1'b0, 32'h10, 32'd0, 32'hDE5ABEEF, 1'b0);
    access("ld_byte", 1'b0, 1'b1, 32'h13, 32'd0, 32'h000000DE, 1'b0);

    // 4: misaligned word load; out-of-range store leaves word 0 intact
    access("ld_misaligned", 1'b0, 1'b0, 32'h11, 32'd0, 32'd0, 1'b1);
    access("st_word0", 1'b1, 1'b0, 32'h0, 32'h0BADF00D, 32'd0, 1'b0);
    access("st_oor", 1'b1, 1'b0, 32'h400, 32'hFFFFFFFF, 32'd0, 1'b1);
    access("ld_word0", 1'b0, 1'b0, 32'h0, 32'd0, 32'h0BADF00D, 1'b0);

    // 5: back-to-back loads with req_valid held high (LATENCY = 2)
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h10, 32'd0);
    exp_q.push_back(32'hDE5ABEEF);
    exp_err_q.push_back(1'b0);
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("b2b_stall_c%0d", c), 32'(stall), 32'(exp_st[c]));
      chk($sformatf("b2b_rvalid_c%0d", c), 32'(rvalid), 32'(exp_rv[c]));
      if (rvalid) pop_check($sformatf("b2b_resp_c%0d", c), rdata, err);
      if (c == 2) begin
        // Second request: byte load of lane 2, held high without a gap.
        drive(1'b0, 1'b1, 32'h12, 32'd0);
        exp_q.push_back(32'h0000005A);
        exp_err_q.push_back(1'b0);
      end
      if (c == 5) req_valid = 1'b0;
      else @(negedge clk);
    end

    // 5b: same pattern on the LATENCY = 1 instance: store then load
    @(negedge clk);
    b_req_valid = 1'b1;
    b_req_write = 1'b1;
    b_req_byte  = 1'b0;
    b_addr      = 32'h4;
    b_wdata     = 32'hCAFEF00D;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("l1_stall_c%0d", c), 32'(b_stall), 32'(exp_st1[c]));
      chk($sformatf("l1_rvalid_c%0d", c), 32'(b_rvalid), 32'(exp_rv1[c]));
      if (c == 1) begin
        chk("l1_store_rdata", b_rdata, 32'd0);
        b_req_write = 1'b0;
      end
      if (c == 3) begin
        chk("l1_load_rdata", b_rdata, 32'hCAFEF00D);
        chk("l1_load_err", 32'(b_err), 32'd0);
        b_req_valid = 1'b0;
      end else begin
        @(negedge clk);
      end
    end

    // Reset while idle clears the held response (rdata currently 0x5A).
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("idle_reset_rdata", rdata, 32'd0);
    chk("idle_reset_err", 32'(err), 32'd0);
    reset = 1'b0;

    // 6: reset in the first WAIT cycle of a store
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h20, 32'h12345678);
    @(negedge clk);
    #1;
    chk("abort_wait_stall", 32'(stall), 32'd1);
    reset     = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_stall", 32'(stall), 32'd0);
    chk("abort_rvalid", 32'(rvalid), 32'd0);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("abort_no_rvalid_c%0d", c), 32'(rvalid), 32'd0);
    end
    access("ld_after_abort", 1'b0, 1'b0, 32'h20, 32'd0, 32'h12345678, 1'b0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
